// File: rtl/vga_scanout.sv
// VGA timing generator and frame-buffer scanout with tear-free buffer flipping.
// Optional feature: define SCANOUT_BORDER_EN to force a 1-pixel white border on the active area.
`timescale 1ns/1ps

module vga_scanout #(
    parameter int HOR_ACTIVE_PIXELS = 640,
    parameter int HOR_FRONT_PORCH   = 16,
    parameter int HOR_SYNC_PULSE    = 96,
    parameter int HOR_BACK_PORCH    = 48,
    parameter int VER_ACTIVE_PIXELS = 480,
    parameter int VER_FRONT_PORCH   = 10,
    parameter int VER_SYNC_PULSE    = 2,
    parameter int VER_BACK_PORCH    = 33,
    localparam int H_TOTAL    = HOR_ACTIVE_PIXELS + HOR_FRONT_PORCH + HOR_SYNC_PULSE + HOR_BACK_PORCH,
    localparam int V_TOTAL    = VER_ACTIVE_PIXELS + VER_FRONT_PORCH + VER_SYNC_PULSE + VER_BACK_PORCH,
    localparam int ADDR_WIDTH = $clog2(HOR_ACTIVE_PIXELS * VER_ACTIVE_PIXELS)
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic [ADDR_WIDTH-1:0] read_addr,
    input  logic                  read_data,
    input  logic                  frame_ready,
    output logic                  swap,
    output logic                  vga_hsync,
    output logic                  vga_vsync,
    output logic                  vga_de,
    output logic                  vga_pixel
);

    localparam int H_W = $clog2(H_TOTAL);
    localparam int V_W = $clog2(V_TOTAL);

    localparam logic [H_W-1:0] H_LAST     = H_W'(H_TOTAL - 1);
    localparam logic [H_W-1:0] H_ACT      = H_W'(HOR_ACTIVE_PIXELS);
    localparam logic [H_W-1:0] H_ACT_LAST = H_W'(HOR_ACTIVE_PIXELS - 1);
    localparam logic [H_W-1:0] HS_FIRST   = H_W'(HOR_ACTIVE_PIXELS + HOR_FRONT_PORCH);
    localparam logic [H_W-1:0] HS_LAST    = H_W'(HOR_ACTIVE_PIXELS + HOR_FRONT_PORCH + HOR_SYNC_PULSE - 1);

    localparam logic [V_W-1:0] V_LAST     = V_W'(V_TOTAL - 1);
    localparam logic [V_W-1:0] V_ACT      = V_W'(VER_ACTIVE_PIXELS);
    localparam logic [V_W-1:0] V_ACT_LAST = V_W'(VER_ACTIVE_PIXELS - 1);
    localparam logic [V_W-1:0] VS_FIRST   = V_W'(VER_ACTIVE_PIXELS + VER_FRONT_PORCH);
    localparam logic [V_W-1:0] VS_LAST    = V_W'(VER_ACTIVE_PIXELS + VER_FRONT_PORCH + VER_SYNC_PULSE - 1);

    logic [H_W-1:0] h_cnt;
    logic [V_W-1:0] v_cnt;
    logic           h_wrap;
    logic           frame_wrap;
    logic           active_s0;
    logic           swap_point;
    logic           pending;

    assign h_wrap     = (h_cnt == H_LAST);
    assign frame_wrap = h_wrap && (v_cnt == V_LAST);
    assign active_s0  = (h_cnt < H_ACT) && (v_cnt < V_ACT);
    assign swap_point = (h_cnt == '0) && (v_cnt == V_ACT);

    // Stage 0: raster position and the matching frame-buffer address.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_wrap) begin
            h_cnt <= '0;
            v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
        end else begin
            h_cnt <= h_cnt + 1'b1;
        end
    end

    // Running count of active pixels already shown this frame; equals v*H_ACTIVE+h on active pixels.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            read_addr <= '0;
        end else if (frame_wrap) begin
            read_addr <= '0;
        end else if (active_s0) begin
            read_addr <= read_addr + 1'b1;
        end
    end

    // Stage 1: control registered once so it lines up with read_data, which returns one clock later.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vga_hsync <= 1'b1;
            vga_vsync <= 1'b1;
            vga_de    <= 1'b0;
        end else begin
            vga_hsync <= !((h_cnt >= HS_FIRST) && (h_cnt <= HS_LAST));
            vga_vsync <= !((v_cnt >= VS_FIRST) && (v_cnt <= VS_LAST));
            vga_de    <= active_s0;
        end
    end

`ifdef SCANOUT_BORDER_EN
    logic border_s0;
    logic border_s1;

    assign border_s0 = active_s0 &&
                       ((h_cnt == '0) || (h_cnt == H_ACT_LAST) ||
                        (v_cnt == '0) || (v_cnt == V_ACT_LAST));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            border_s1 <= 1'b0;
        end else begin
            border_s1 <= border_s0;
        end
    end

    assign vga_pixel = vga_de & (read_data | border_s1);
`else
    // read_data already carries the stage-1 pixel; gating by the registered de keeps blanking black.
    assign vga_pixel = vga_de & read_data;
`endif

    // A frame_ready landing on the swap point itself is served by that swap, so it never sets pending.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending <= 1'b0;
        end else if (swap_point) begin
            pending <= 1'b0;
        end else if (frame_ready) begin
            pending <= 1'b1;
        end
    end

    // Swap point is the first clock of vblank, so the flip can never land mid-picture.
    assign swap = swap_point & (pending | frame_ready);

endmodule

// File: tb/tb_vga_scanout.sv
// Randomized self-checking bench for vga_scanout: a shrunken-timing instance checked every clock
// against a position-based reference model, plus a default-timing instance checked over its first lines.
`timescale 1ns/1ps

module tb_vga_scanout;

    typedef struct packed {
        int ha, hfp, hsw, hbp, va, vfp, vsw, vbp;
    } timing_t;

    localparam int S_HA = 10, S_HFP = 2, S_HSW = 3, S_HBP = 2;
    localparam int S_VA = 6,  S_VFP = 1, S_VSW = 2, S_VBP = 2;
    localparam timing_t TS = '{ha: S_HA, hfp: S_HFP, hsw: S_HSW, hbp: S_HBP,
                               va: S_VA, vfp: S_VFP, vsw: S_VSW, vbp: S_VBP};
    localparam timing_t TF = '{ha: 640, hfp: 16, hsw: 96, hbp: 48,
                               va: 480, vfp: 10, vsw: 2, vbp: 33};
    localparam int S_AW = $clog2(S_HA * S_VA);
    localparam int F_AW = $clog2(640 * 480);
    localparam int S_FT = (S_HA + S_HFP + S_HSW + S_HBP) * (S_VA + S_VFP + S_VSW + S_VBP);
    localparam int FULL_LIMIT = 1500;
`ifdef SCANOUT_BORDER_EN
    localparam bit BORDER_EN = 1'b1;
`else
    localparam bit BORDER_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    logic frame_ready;
    logic frame_ready_f;

    logic [S_AW-1:0] read_addr_s;
    logic read_data_s, swap_s, hsync_s, vsync_s, de_s, pixel_s;
    logic [F_AW-1:0] read_addr_f;
    logic read_data_f, swap_f, hsync_f, vsync_f, de_f, pixel_f;

    bit fb_small [64];

    int checks = 0;
    int errors = 0;
    int k;
    int ready_cnt;
    int swaps_in_frame;
    int de_seen, hs_low_seen, vs_low_seen, px_seen;
    int f_de_seen, f_hs_low_seen;

    always #5 clk = ~clk;

    vga_scanout #(
        .HOR_ACTIVE_PIXELS(S_HA), .HOR_FRONT_PORCH(S_HFP), .HOR_SYNC_PULSE(S_HSW), .HOR_BACK_PORCH(S_HBP),
        .VER_ACTIVE_PIXELS(S_VA), .VER_FRONT_PORCH(S_VFP), .VER_SYNC_PULSE(S_VSW), .VER_BACK_PORCH(S_VBP)
    ) dut_small (
        .clk(clk), .rst(rst), .read_addr(read_addr_s), .read_data(read_data_s),
        .frame_ready(frame_ready), .swap(swap_s), .vga_hsync(hsync_s), .vga_vsync(vsync_s),
        .vga_de(de_s), .vga_pixel(pixel_s)
    );

    vga_scanout dut_full (
        .clk(clk), .rst(rst), .read_addr(read_addr_f), .read_data(read_data_f),
        .frame_ready(frame_ready_f), .swap(swap_f), .vga_hsync(hsync_f), .vga_vsync(vsync_f),
        .vga_de(de_f), .vga_pixel(pixel_f)
    );

    // Frame-buffer models: synchronous read, data one clock after the address.
    always @(posedge clk) begin
        read_data_s <= fb_small[read_addr_s];
        read_data_f <= read_addr_f[0];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at k=%0d: got %0d expected %0d", tag, k, got, exp);
        end
    endtask

    function automatic int h_total(input timing_t t);
        return t.ha + t.hfp + t.hsw + t.hbp;
    endfunction

    function automatic int v_total(input timing_t t);
        return t.va + t.vfp + t.vsw + t.vbp;
    endfunction

    function automatic void position(input timing_t t, input int kk, output int h, output int v);
        h = kk % h_total(t);
        v = (kk / h_total(t)) % v_total(t);
    endfunction

    function automatic bit in_active(input timing_t t, input int h, input int v);
        return (h < t.ha) && (v < t.va);
    endfunction

    // Number of visible pixels that precede (h,v) in raster order within its frame.
    function automatic int pixels_before(input timing_t t, input int h, input int v);
        if (v < t.va) return v * t.ha + ((h < t.ha) ? h : t.ha);
        return t.va * t.ha;
    endfunction

    function automatic bit hs_low(input timing_t t, input int h);
        return (h >= t.ha + t.hfp) && (h < t.ha + t.hfp + t.hsw);
    endfunction

    function automatic bit vs_low(input timing_t t, input int v);
        return (v >= t.va + t.vfp) && (v < t.va + t.vfp + t.vsw);
    endfunction

    function automatic bit on_border(input timing_t t, input int h, input int v);
        return in_active(t, h, v) && (h == 0 || h == t.ha - 1 || v == 0 || v == t.va - 1);
    endfunction

    // Expected outputs after kk clock edges since reset release; stage-1 outputs reflect position kk-1.
    task automatic check_video(input string pfx, input timing_t t, input int kk, input int aw,
                               input bit small_fb, input logic [31:0] addr,
                               input logic hs, input logic vs, input logic de, input logic px);
        int h, v, hp, vp, a;
        bit e_hs, e_vs, e_de, e_px;
        position(t, kk, h, v);
        check({pfx, "read_addr"}, addr, 32'(pixels_before(t, h, v) % (1 << aw)));
        if (kk == 0) begin
            e_hs = 1'b1; e_vs = 1'b1; e_de = 1'b0; e_px = 1'b0;
        end else begin
            position(t, kk - 1, hp, vp);
            a    = pixels_before(t, hp, vp);
            e_de = in_active(t, hp, vp);
            e_hs = !hs_low(t, hp);
            e_vs = !vs_low(t, vp);
            e_px = e_de && ((BORDER_EN && on_border(t, hp, vp)) ||
                            (small_fb ? fb_small[a % 64] : a[0]));
        end
        check({pfx, "hsync"}, 32'(hs), 32'(e_hs));
        check({pfx, "vsync"}, 32'(vs), 32'(e_vs));
        check({pfx, "de"},    32'(de), 32'(e_de));
        check({pfx, "pixel"}, 32'(px), 32'(e_px));
    endtask

    task automatic check_reset_values();
        check("rst_s_read_addr", 32'(read_addr_s), 32'd0);
        check("rst_s_hsync",     32'(hsync_s),     32'd1);
        check("rst_s_vsync",     32'(vsync_s),     32'd1);
        check("rst_s_de",        32'(de_s),        32'd0);
        check("rst_s_pixel",     32'(pixel_s),     32'd0);
        check("rst_s_swap",      32'(swap_s),      32'd0);
        check("rst_f_read_addr", 32'(read_addr_f), 32'd0);
        check("rst_f_hsync",     32'(hsync_f),     32'd1);
        check("rst_f_de",        32'(de_f),        32'd0);
    endtask

    task automatic clear_stats();
        ready_cnt = 0; swaps_in_frame = 0;
        de_seen = 0; hs_low_seen = 0; vs_low_seen = 0; px_seen = 0;
        f_de_seen = 0; f_hs_low_seen = 0;
    endtask

    // One clock: drive frame_ready, check both instances against the model, advance to next negedge.
    task automatic step(input bit fr);
        int h, v;
        bit sp, exp_swap;
        frame_ready = fr;
        #1;
        position(TS, k, h, v);
        check_video("s_", TS, k, S_AW, 1'b1, 32'(read_addr_s), hsync_s, vsync_s, de_s, pixel_s);
        if (h == S_HA - 1 && v == S_VA - 1)
            check("s_last_pixel_addr", 32'(read_addr_s), 32'(S_HA * S_VA - 1));
        if (h == 0 && v == 0 && k > 0) begin
            check("s_frame_start_addr", 32'(read_addr_s), 32'd0);
            check("s_swaps_per_frame_le1", 32'(swaps_in_frame <= 1), 32'd1);
            swaps_in_frame = 0;
        end
        sp = (h == 0) && (v == S_VA);
        exp_swap = sp && ((ready_cnt + int'(fr)) > 0);
        check("s_swap", 32'(swap_s), 32'(exp_swap));
        ready_cnt = sp ? 0 : ready_cnt + int'(fr);
        if (swap_s === 1'b1) swaps_in_frame++;
        if (k >= 1) begin
            de_seen     += int'(de_s === 1'b1);
            hs_low_seen += int'(hsync_s === 1'b0);
            vs_low_seen += int'(vsync_s === 1'b0);
            px_seen     += int'(pixel_s === 1'b1);
        end
        if (k < FULL_LIMIT) begin
            check_video("f_", TF, k, F_AW, 1'b0, 32'(read_addr_f), hsync_f, vsync_f, de_f, pixel_f);
            check("f_swap", 32'(swap_f), 32'd0);
            if (k >= 1 && k <= 800) begin
                f_de_seen     += int'(de_f === 1'b1);
                f_hs_low_seen += int'(hsync_f === 1'b0);
            end
        end
        @(negedge clk);
        k++;
    endtask

    // Directed frame_ready schedule for the first frames, random pulses afterwards.
    function automatic bit fr_schedule(input int f, input int h, input int v);
        case (f)
            0: return (h == 5 && v == 2);
            1: return 1'b0;
            2: return (h == 0 && v == S_VA);
            3: return (h == 3 && v == 1) || (h == 9 && v == 3) || (h == 1 && v == 5);
            6: return 1'b0;
            default: return ($urandom_range(0, 39) == 0);
        endcase
    endfunction

    task automatic release_reset();
        @(negedge clk);
        rst = 1'b0;
        k = 0;
        clear_stats();
    endtask

    initial begin
        int h, v;
        rst = 1'b1;
        frame_ready = 1'b0;
        frame_ready_f = 1'b0;
        k = 0;
        clear_stats();
        for (int i = 0; i < 64; i++) fb_small[i] = bit'($urandom_range(0, 1));
        repeat (3) @(negedge clk);
        #1;
        check_reset_values();

        // Free-run 8 frames with directed then random frame_ready activity.
        release_reset();
        for (int i = 0; i <= 8 * S_FT; i++) begin
            position(TS, k, h, v);
            step(fr_schedule(k / S_FT, h, v));
        end
        check("s_de_per_8_frames",     32'(de_seen),     32'(8 * S_HA * S_VA));
        check("s_hsync_low_8_frames",  32'(hs_low_seen), 32'(8 * v_total(TS) * S_HSW));
        check("s_vsync_low_8_frames",  32'(vs_low_seen), 32'(8 * S_VSW * h_total(TS)));
        check("f_de_line0",            32'(f_de_seen),     32'd640);
        check("f_hsync_low_line0",     32'(f_hs_low_seen), 32'd96);

        // Mid-frame reset with a swap pending: outputs drop at once and the pending swap is discarded.
        for (int i = 0; i < 2 * h_total(TS) + 7; i++) begin
            position(TS, k, h, v);
            step(h == 2 && v == 1);
        end
        rst = 1'b1;
        #1;
        check_reset_values();
        repeat (2) @(negedge clk);
        release_reset();
        for (int i = 0; i <= S_FT; i++) step(1'b0);
        check("s_no_swap_after_reset", 32'(swaps_in_frame), 32'd0);

        // All-zero buffer: only border pixels (if enabled) may light up.
        rst = 1'b1;
        for (int i = 0; i < 64; i++) fb_small[i] = 1'b0;
        repeat (2) @(negedge clk);
        release_reset();
        for (int i = 0; i <= S_FT; i++) step(bit'($urandom_range(0, 19) == 0));
        check("s_zero_buffer_lit_pixels", 32'(px_seen),
              32'(BORDER_EN ? (2 * S_HA + 2 * S_VA - 4) : 0));
        check("s_de_one_frame", 32'(de_seen), 32'(S_HA * S_VA));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
